uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, 3-sample majority vote, data/parity/stop framing and
// a small receive FIFO drained through a valid/ready handshake.
module uart_rx_cfg #(
  parameter int unsigned CLOCK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE   = 4000000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          uart_clock,
  input  logic                          uart_reset,
  input  logic                          uart_d_in,
  output logic [DATA_BITS-1:0]          uart_d_out,
  output logic                          uart_parity_err,
  output logic                          uart_frame_err,
  output logic                          uart_valid,
  input  logic                          uart_ready,
  output logic                          uart_overrun,
  input  logic                          uart_overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   uart_level
);

  localparam int unsigned BitCycles  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned CntW       = $clog2(BitCycles);
  localparam int unsigned BcW        = $clog2(DATA_BITS);
  localparam int unsigned Aw         = $clog2(FIFO_DEPTH);
  localparam int unsigned Lw         = Aw + 1;
  localparam int unsigned Ww         = DATA_BITS + 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic                 sync1_q, sync2_q;
  logic [2:0]           hist_q;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BcW-1:0]       bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push;
  logic [Ww-1:0]        push_word;

  logic                 rx_s, sample, fall, bit_last, half_last;

  assign rx_s      = sync2_q;
  assign sample    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign fall      = hist_q[0] & ~rx_s;
  assign bit_last  = (cnt_q == CntW'(BitCycles - 1));
  assign half_last = (cnt_q == CntW'(HalfCycles - 1));

  // Input flops reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= uart_d_in;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], rx_s};
    end
  end

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
    push_word = '0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (half_last) begin
          cnt_d   = '0;
          state_d = sample ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_last) begin
          cnt_d   = '0;
          shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BcW'(1);
          if (bit_q == BcW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (bit_last) begin
          cnt_d   = '0;
          perr_d  = (^shreg_q) ^ sample ^ (PARITY_MODE == 2);
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_last) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~sample;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            push      = 1'b1;
            push_word = {ferr_d, perr_q, shreg_q};
            state_d   = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Receive FIFO; pointers carry one extra bit so full and empty are distinguishable.
  logic [Ww-1:0] mem_q [FIFO_DEPTH];
  logic [Lw-1:0] wptr_q, rptr_q, level;
  logic          full, pop, push_ok, ovr_q;
  logic [Ww-1:0] head;

  assign level   = wptr_q - rptr_q;
  assign full    = (level == Lw'(FIFO_DEPTH));
  assign pop     = (level != '0) & uart_ready;
  assign push_ok = push & (~full | pop);
  assign head    = mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + Lw'(1);
      if (pop)     rptr_q <= rptr_q + Lw'(1);
      ovr_q <= (push & full & ~pop) | (ovr_q & ~uart_overrun_clr);
    end
  end

  always_ff @(posedge uart_clock) begin
    if (push_ok) mem_q[wptr_q[Aw-1:0]] <= push_word;
  end

  assign uart_valid      = (level != '0);
  assign uart_d_out      = uart_valid ? head[DATA_BITS-1:0] : '0;
  assign uart_parity_err = uart_valid & head[DATA_BITS];
  assign uart_frame_err  = uart_valid & head[DATA_BITS+1];
  assign uart_overrun    = ovr_q;
  assign uart_level      = level;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E2, 8O1) driven from frame-level stimulus and
// checked against a word-queue model of what each receiver must deliver.
module tb_uart_rx_cfg;

  localparam int Bit = 12;
  localparam int PM [3] = '{0, 1, 2};
  localparam int NS [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       line [3];
  logic       rdy  [3];
  logic       clr  [3];
  logic [7:0] dout [3];
  logic       perr [3];
  logic       ferr [3];
  logic       vld  [3];
  logic       ovr  [3];
  logic [2:0] lvl  [3];

  always #5 clk = ~clk;

  uart_rx_cfg #(.PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(line[0]), .uart_d_out(dout[0]),
    .uart_parity_err(perr[0]), .uart_frame_err(ferr[0]), .uart_valid(vld[0]),
    .uart_ready(rdy[0]), .uart_overrun(ovr[0]), .uart_overrun_clr(clr[0]), .uart_level(lvl[0])
  );
  uart_rx_cfg #(.PARITY_MODE(1), .STOP_BITS(2)) u_dut1 (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(line[1]), .uart_d_out(dout[1]),
    .uart_parity_err(perr[1]), .uart_frame_err(ferr[1]), .uart_valid(vld[1]),
    .uart_ready(rdy[1]), .uart_overrun(ovr[1]), .uart_overrun_clr(clr[1]), .uart_level(lvl[1])
  );
  uart_rx_cfg #(.PARITY_MODE(2), .STOP_BITS(1)) u_dut2 (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(line[2]), .uart_d_out(dout[2]),
    .uart_parity_err(perr[2]), .uart_frame_err(ferr[2]), .uart_valid(vld[2]),
    .uart_ready(rdy[2]), .uart_overrun(ovr[2]), .uart_overrun_clr(clr[2]), .uart_level(lvl[2])
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [9:0] mq [3][64];
  int         mh [3];
  int         mt [3];
  logic       ov_exp [3];
  logic [9:0] last_pop [3];
  int         pop_cnt [3];
  int         rf_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected FIFO entry {frame_err, parity_err, data} straight from the framing rules.
  function automatic logic [9:0] model_word(input int i, input logic [7:0] d, input logic par,
                                            input logic s1, input logic s2);
    logic pe, fe;
    pe = (PM[i] == 0) ? 1'b0 : ((PM[i] == 1) ? ((^d) ^ par) : ~((^d) ^ par));
    fe = ~s1 | ((NS[i] == 2) & ~s2);
    return {fe, pe, d};
  endfunction

  // A full FIFO still accepts the word when the consumer pops on the same edge.
  task automatic model_push(input int i, input logic [9:0] w);
    if ((mt[i] - mh[i]) < 4 || rdy[i]) begin
      mq[i][mt[i] % 64] = w;
      mt[i]++;
    end else begin
      ov_exp[i] = 1'b1;
    end
  endtask

  // Drives one frame, one bit per 12 cycles. The word lands in the FIFO on the edge after
  // cycle 8 + 12*(nbits-1); the model is updated just before that edge.
  task automatic send_frame(input int i, input logic [7:0] d, input logic par, input logic s1,
                            input logic s2, input logic [7:0] gmask, input bit pop_at_push,
                            input int abort_at);
    logic bits [12];
    int   nb, pushc, b;
    logic v;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
    nb = 9;
    if (PM[i] != 0) begin bits[nb] = par; nb++; end
    bits[nb] = s1; nb++;
    if (NS[i] == 2) begin bits[nb] = s2; nb++; end
    pushc = 8 + Bit * (nb - 1);
    for (int c = 0; c < Bit * nb; c++) begin
      b = c / Bit;
      v = bits[b];
      if (b >= 1 && b <= 8 && gmask[b-1] && (c % Bit) == 4) v = ~v;
      line[i] = v;
      if (c == abort_at) begin
        rst = 1'b1;
        line[i] = 1'b1;
        for (int j = 0; j < 3; j++) begin mh[j] = mt[j]; ov_exp[j] = 1'b0; end
        idle(2);
        rst = 1'b0;
        return;
      end
      if (c == pushc) begin
        if (pop_at_push) rdy[i] = 1'b1;
        #1;
        model_push(i, model_word(i, d, par, s1, s2));
      end
      if (c == pushc + 1 && pop_at_push) rdy[i] = 1'b0;
      @(posedge clk);
      #1;
    end
    line[i] = 1'b1;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          if (vld[i] && rdy[i]) begin
            if (mt[i] == mh[i]) begin
              chk($sformatf("spurious_word_dut%0d", i), 32'(vld[i]), 32'd0);
            end else begin
              chk($sformatf("pop_word_dut%0d", i), {22'd0, ferr[i], perr[i], dout[i]},
                  {22'd0, mq[i][mh[i] % 64]});
              mh[i]++;
            end
            last_pop[i] = {ferr[i], perr[i], dout[i]};
            pop_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic rand_frames(input int i);
    logic [7:0] d, gm;
    logic       par, s1, s2, last;
    repeat (12) begin
      d  = 8'($urandom);
      par = (PM[i] == 2) ? ~(^d) : (^d);
      if ($urandom_range(0, 4) == 0) par = ~par;
      s1 = ($urandom_range(0, 9) != 0);
      s2 = ($urandom_range(0, 9) != 0);
      gm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      send_frame(i, d, par, s1, s2, gm, 1'b0, -1);
      last = (NS[i] == 2) ? s2 : s1;
      idle(last ? int'($urandom_range(0, 3)) : 4 + int'($urandom_range(0, 3)));
    end
    rf_done++;
  endtask

  int pc;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1; rdy[i] = 1'b0; clr[i] = 1'b0;
      mh[i] = 0; mt[i] = 0; ov_exp[i] = 1'b0; last_pop[i] = '0; pop_cnt[i] = 0;
    end
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_level%0d", i), 32'(lvl[i]), 32'd0);
      chk($sformatf("rst_overrun%0d", i), 32'(ovr[i]), 32'd0);
      chk($sformatf("rst_out%0d", i), {22'd0, ferr[i], perr[i], dout[i]}, 32'd0);
    end
    rst = 1'b0;
    fork compare_loop(); join_none
    idle(4);
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;

    // 8N1 basic words and exact latency of the first one.
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
      begin
        repeat (117) @(negedge clk);
        chk("latency_before", 32'(vld[0]), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(vld[0]), 32'd1);
        chk("latency_data", 32'(dout[0]), 32'hA5);
        chk("latency_flags", {30'd0, ferr[0], perr[0]}, 32'd0);
        @(negedge clk);
        chk("valid_pulse", 32'(vld[0]), 32'd0);
      end
    join
    idle(4);
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(4);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(4);
    chk("word_ff", 32'(last_pop[0]), 32'h0FF);
    chk("count_8n1", 32'(pop_cnt[0]), 32'd3);

    // Even and odd parity, good and bad parity bit.
    send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(2);
    chk("even_par_ok", 32'(last_pop[1]), 32'h003);
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(2);
    chk("even_par_bad", 32'(last_pop[1]), 32'h103);
    send_frame(2, 8'h03, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(2);
    chk("odd_par_bad", 32'(last_pop[2]), 32'h103);
    send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(2);
    chk("odd_par_ok", 32'(last_pop[2]), 32'h003);

    // Stop-bit errors.
    send_frame(0, 8'h5C, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, -1);
    idle(4);
    chk("stop_err", 32'(last_pop[0]), 32'h25C);
    send_frame(1, 8'h81, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, -1);
    idle(4);
    chk("stop2_err", 32'(last_pop[1]), 32'h281);

    // False starts: 1-cycle and 3-cycle low pulses.
    pc = pop_cnt[0];
    line[0] = 1'b0; idle(1); line[0] = 1'b1; idle(30);
    line[0] = 1'b0; idle(3); line[0] = 1'b1; idle(30);
    chk("glitch_level", 32'(lvl[0]), 32'd0);
    chk("glitch_nopush", 32'(pop_cnt[0] - pc), 32'd0);
    send_frame(0, 8'h96, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(2);
    chk("after_glitch", 32'(last_pop[0]), 32'h096);

    // Overrun with the consumer stalled.
    rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_frame(0, 8'h11 + 8'(k), 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
      idle(2);
    end
    chk("ovr_level", 32'(lvl[0]), 32'd4);
    chk("ovr_flag", 32'(ovr[0]), 32'd1);
    chk("ovr_model", 32'(ovr[0]), 32'(ov_exp[0]));
    chk("ovr_head", 32'(dout[0]), 32'h11);
    pc = pop_cnt[0];
    rdy[0] = 1'b1;
    idle(6);
    chk("ovr_drain_cnt", 32'(pop_cnt[0] - pc), 32'd4);
    chk("ovr_drain_last", 32'(last_pop[0]), 32'h014);
    chk("ovr_sticky", 32'(ovr[0]), 32'd1);
    clr[0] = 1'b1; idle(1); clr[0] = 1'b0;
    ov_exp[0] = 1'b0;
    chk("ovr_clear", 32'(ovr[0]), 32'd0);

    // Full FIFO with a pop on the very edge of the fifth push.
    rdy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_frame(0, 8'h21 + 8'(k), 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
      idle(2);
    end
    send_frame(0, 8'h25, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, -1);
    idle(2);
    chk("coinc_ovr", 32'(ovr[0]), 32'd0);
    chk("coinc_level", 32'(lvl[0]), 32'd4);
    chk("coinc_popped", 32'(last_pop[0]), 32'h021);
    chk("coinc_head", 32'(dout[0]), 32'h22);
    rdy[0] = 1'b1;
    idle(6);
    chk("coinc_last", 32'(last_pop[0]), 32'h025);
    chk("coinc_empty", 32'(lvl[0]), 32'd0);

    // Reset in the middle of a data bit, then a clean frame.
    pc = pop_cnt[0];
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 40);
    idle(4);
    chk("midrst_level", 32'(lvl[0]), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    idle(2);
    chk("midrst_count", 32'(pop_cnt[0] - pc), 32'd1);
    chk("midrst_word", 32'(last_pop[0]), 32'h03C);

    // Single-cycle glitches inside every data bit.
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, -1);
    idle(2);
    chk("vote_00", 32'(last_pop[0]), 32'h000);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, -1);
    idle(2);
    chk("vote_5a", 32'(last_pop[0]), 32'h05A);

    // Randomised frames on all three receivers with a random consumer.
    rf_done = 0;
    fork
      rand_frames(0);
      rand_frames(1);
      rand_frames(2);
      begin
        while (rf_done < 3) begin
          @(posedge clk);
          #1;
          for (int j = 0; j < 3; j++) rdy[j] = 1'($urandom_range(0, 1));
        end
      end
    join
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
    idle(20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rand_level%0d", i), 32'(lvl[i]), 32'd0);
      chk($sformatf("rand_model_left%0d", i), 32'(mt[i] - mh[i]), 32'd0);
      chk($sformatf("rand_overrun%0d", i), 32'(ovr[i]), 32'(ov_exp[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
